// File: rtl/la_parity_pkg.sv
// Shared definitions for the sequential parity engine: FSM encodings and
// the helper functions that size the run counter and the requester index.
package la_parity_pkg;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    // Number of RUN cycles: one 3-bit chunk per cycle.
    function automatic int calc_k(input int width);
        return (width + 2) / 3;
    endfunction

    // Counter width able to hold the value K.
    function automatic int calc_cnt_w(input int width);
        return $clog2(calc_k(width) + 1);
    endfunction

    // Width of a requester index, never less than one bit.
    function automatic int calc_id_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/la_xor4.sv
// Datapath slice shared by all requesters: folds three data bits into the
// running parity accumulator.
module la_xor4 (
    input  logic acc,
    input  logic bit0,
    input  logic bit1,
    input  logic bit2,
    output logic y
);

    assign y = acc ^ bit0 ^ bit1 ^ bit2;

endmodule

// File: rtl/la_parity_seq.sv
// Round-robin arbitrated, bit-serial parity engine. One requester at a time
// is granted, its word is folded three bits per cycle through la_xor4, and
// the result is held in DONE until the consumer accepts it.
// Build option: define LA_PARITY_SEQ_ODD_EN to seed the accumulator with 1
// (odd parity); by default it is seeded with 0 (even parity).
module la_parity_seq
    import la_parity_pkg::*;
#(
    parameter     PROP  = "DEFAULT",
    parameter int N     = 4,
    parameter int WIDTH = 8
) (
    input  logic                         clk,
    input  logic                         nreset,
    input  logic [N-1:0]                 req_valid,
    output logic [N-1:0]                 req_ready,
    input  logic [N*WIDTH-1:0]           req_data,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic                         out_parity,
    output logic [calc_id_w(N)-1:0]      out_id,
    output logic                         busy
);

    localparam int K     = calc_k(WIDTH);
    localparam int CNT_W = calc_cnt_w(WIDTH);
    localparam int ID_W  = calc_id_w(N);
    localparam int DW    = 3 * K;   // word zero-padded to whole chunks

`ifdef LA_PARITY_SEQ_ODD_EN
    localparam logic ACC_INIT = 1'b1;
`else
    localparam logic ACC_INIT = 1'b0;
`endif

    logic [1:0]       state_q;
    logic [ID_W-1:0]  last_q;
    logic [ID_W-1:0]  id_q;
    logic [DW-1:0]    data_q;
    logic             acc_q;
    logic [CNT_W-1:0] cnt_q;

    logic             found;
    logic [ID_W-1:0]  gnt_idx;
    logic [N-1:0]     gnt_oh;
    logic [WIDTH-1:0] sel_data;
    logic             xor_y;

    // Round-robin pick: lowest valid index above last_q, else wrap to the
    // lowest valid index overall.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first so no latch is inferred.
        found   = 1'b0;
        gnt_idx = '0;
        for (int i = 0; i < N; i++) begin
            if (!found && req_valid[i] && (ID_W'(i) > last_q)) begin
                found   = 1'b1;
                gnt_idx = ID_W'(i);
            end
        end
        for (int i = 0; i < N; i++) begin
            if (!found && req_valid[i]) begin
                found   = 1'b1;
                gnt_idx = ID_W'(i);
            end
        end
    end

    // Decode the grant to one-hot and select the granted requester's word.
    always_comb begin
        gnt_oh   = '0;
        sel_data = '0;
        for (int i = 0; i < N; i++) begin
            if (gnt_idx == ID_W'(i)) begin
                gnt_oh[i] = found;
                sel_data  = req_data[i*WIDTH +: WIDTH];
            end
        end
    end

    // Accept only in IDLE and never while reset is asserted.
    assign req_ready = (state_q == IDLE && nreset) ? gnt_oh : '0;

    la_xor4 u_xor4 (
        .acc  (acc_q),
        .bit0 (data_q[0]),
        .bit1 (data_q[1]),
        .bit2 (data_q[2]),
        .y    (xor_y)
    );

    // Sequencer: capture on grant, fold K chunks, then hold the result.
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            state_q <= IDLE;
            last_q  <= ID_W'(N - 1);
            id_q    <= '0;
            data_q  <= '0;
            acc_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
            case (state_q)
                IDLE: begin
                    if (found) begin
                        state_q <= RUN;
                        last_q  <= gnt_idx;
                        id_q    <= gnt_idx;
                        data_q  <= DW'(sel_data);
                        acc_q   <= ACC_INIT;
                        cnt_q   <= CNT_W'(K);
                    end
                end
                RUN: begin
                    acc_q  <= xor_y;
                    data_q <= data_q >> 3;
                    cnt_q  <= cnt_q - CNT_W'(1);
                    if (cnt_q == CNT_W'(1)) begin
                        state_q <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign out_valid  = (state_q == DONE);
    assign out_parity = out_valid & acc_q;
    assign out_id     = id_q;
    assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_la_parity_seq.sv
// Directed bench for la_parity_seq: a default N=4/WIDTH=8 instance and a
// WIDTH=1 instance sharing clock and reset.
module tb_la_parity_seq;

`ifdef LA_PARITY_SEQ_ODD_EN
    localparam logic ODD = 1'b1;
`else
    localparam logic ODD = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        nreset;
    logic [3:0]  req_valid;
    logic [3:0]  req_ready;
    logic [31:0] req_data;
    logic        out_valid;
    logic        out_ready;
    logic        out_parity;
    logic [1:0]  out_id;
    logic        busy;

    logic [3:0]  w1_req_valid;
    logic [3:0]  w1_req_ready;
    logic [3:0]  w1_req_data;
    logic        w1_out_valid;
    logic        w1_out_ready;
    logic        w1_out_parity;
    logic [1:0]  w1_out_id;
    logic        w1_busy;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    la_parity_seq #(.N(4), .WIDTH(8)) dut (
        .clk        (clk),
        .nreset     (nreset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_data   (req_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_parity (out_parity),
        .out_id     (out_id),
        .busy       (busy)
    );

    la_parity_seq #(.N(4), .WIDTH(1)) dut_w1 (
        .clk        (clk),
        .nreset     (nreset),
        .req_valid  (w1_req_valid),
        .req_ready  (w1_req_ready),
        .req_data   (w1_req_data),
        .out_valid  (w1_out_valid),
        .out_ready  (w1_out_ready),
        .out_parity (w1_out_parity),
        .out_id     (w1_out_id),
        .busy       (w1_busy)
    );

    // Advance cycles until out_valid, counting cycles since the grant cycle.
    task automatic wait_result(input bit drop, output int lat);
        lat = 0;
        do begin
            @(negedge clk);
            if (drop) req_valid = '0;
            lat++;
            #1;
            if (!out_valid) begin
                checks++;
                if (busy !== 1'b1) begin
                    errors++;
                    $display("FAIL busy_run: got %0b expected 1", busy);
                end
            end
        end while (!out_valid && lat < 12);
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        nreset = 1'b0;
        @(negedge clk);
        nreset = 1'b1;
    endtask

    task automatic test_reset();
        nreset = 1'b0;
        req_valid = 4'hF;
        out_ready = 1'b0;
        @(negedge clk);
        #1;
        checks++;
        if (req_ready !== 4'h0) begin errors++; $display("FAIL rst_ready: got %0h expected 0", req_ready); end
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_valid: got %0b expected 0", out_valid); end
        checks++;
        if (out_parity !== 1'b0) begin errors++; $display("FAIL rst_parity: got %0b expected 0", out_parity); end
        checks++;
        if (out_id !== 2'd0) begin errors++; $display("FAIL rst_id: got %0d expected 0", out_id); end
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %0b expected 0", busy); end
        checks++;
        if (w1_busy !== 1'b0 || w1_out_valid !== 1'b0) begin
            errors++; $display("FAIL rst_w1: got busy=%0b valid=%0b expected 0 0", w1_busy, w1_out_valid);
        end
        @(negedge clk);
        req_valid = '0;
        nreset = 1'b1;
    endtask

    task automatic test_single();
        int lat;
        @(negedge clk);
        req_data = '0;
        req_data[7:0] = 8'hA5;
        req_valid = 4'b0001;
        out_ready = 1'b1;
        #1;
        checks++;
        if (req_ready !== 4'b0001) begin errors++; $display("FAIL single_grant: got %0h expected 1", req_ready); end
        wait_result(1'b1, lat);
        checks++;
        if (lat != 4) begin errors++; $display("FAIL single_latency: got %0d expected 4", lat); end
        checks++;
        if (out_parity !== (1'b0 ^ ODD)) begin errors++; $display("FAIL single_parity: got %0b expected %0b", out_parity, ODD); end
        checks++;
        if (out_id !== 2'd0) begin errors++; $display("FAIL single_id: got %0d expected 0", out_id); end
        @(negedge clk);
        #1;
        checks++;
        if (out_valid !== 1'b0 || busy !== 1'b0) begin
            errors++; $display("FAIL single_idle: got valid=%0b busy=%0b expected 0 0", out_valid, busy);
        end
    endtask

    task automatic test_round_robin();
        int g = 0;
        int last_c = 0;
        int lat;
        logic [3:0] exp_par = 4'b0101;   // parities of 01,03,07,0F
        pulse_reset();
        req_data = {8'h0F, 8'h07, 8'h03, 8'h01};
        req_valid = 4'hF;
        out_ready = 1'b1;
        for (int c = 0; c < 40 && g < 5; c++) begin
            #1;
            if (req_ready !== 4'h0) begin
                checks++;
                if (req_ready !== 4'(1 << (g % 4))) begin
                    errors++; $display("FAIL rr_order: got %0h expected %0h", req_ready, 4'(1 << (g % 4)));
                end
                if (g > 0) begin
                    checks++;
                    if (c - last_c != 5) begin errors++; $display("FAIL rr_spacing: got %0d expected 5", c - last_c); end
                end
                last_c = c;
                g++;
            end else if (out_valid) begin
                checks++;
                if (out_id !== 2'((g - 1) % 4)) begin
                    errors++; $display("FAIL rr_id: got %0d expected %0d", out_id, (g - 1) % 4);
                end
                checks++;
                if (out_parity !== (exp_par[(g - 1) % 4] ^ ODD)) begin
                    errors++; $display("FAIL rr_parity: got %0b expected %0b", out_parity, exp_par[(g - 1) % 4] ^ ODD);
                end
            end
            @(negedge clk);
        end
        checks++;
        if (g != 5) begin errors++; $display("FAIL rr_count: got %0d expected 5", g); end
        req_valid = '0;
        wait_result(1'b1, lat);
        checks++;
        if (out_id !== 2'd0 || out_parity !== (1'b1 ^ ODD)) begin
            errors++; $display("FAIL rr_last: got id=%0d par=%0b expected 0 %0b", out_id, out_parity, 1'b1 ^ ODD);
        end
        @(negedge clk);
    endtask

    task automatic test_hold();
        int lat;
        req_data[23:16] = 8'h07;
        req_valid = 4'b0100;
        out_ready = 1'b0;
        #1;
        checks++;
        if (req_ready !== 4'b0100) begin errors++; $display("FAIL hold_grant: got %0h expected 4", req_ready); end
        wait_result(1'b1, lat);
        checks++;
        if (lat != 4) begin errors++; $display("FAIL hold_latency: got %0d expected 4", lat); end
        for (int i = 0; i < 4; i++) begin
            if (i > 0) begin
                @(negedge clk);
                #1;
            end
            checks++;
            if (out_valid !== 1'b1 || busy !== 1'b1) begin
                errors++; $display("FAIL hold_valid: got valid=%0b busy=%0b expected 1 1 (cycle %0d)", out_valid, busy, i);
            end
            checks++;
            if (out_id !== 2'd2 || out_parity !== (1'b1 ^ ODD)) begin
                errors++; $display("FAIL hold_result: got id=%0d par=%0b expected 2 %0b", out_id, out_parity, 1'b1 ^ ODD);
            end
            if (i == 3) out_ready = 1'b1;
        end
        @(negedge clk);
        #1;
        checks++;
        if (out_valid !== 1'b0 || busy !== 1'b0) begin
            errors++; $display("FAIL hold_release: got valid=%0b busy=%0b expected 0 0", out_valid, busy);
        end
    endtask

    task automatic test_reset_mid_run();
        int lat;
        bit seen = 1'b0;
        @(negedge clk);
        req_data[15:8] = 8'hFF;
        req_valid = 4'b0010;
        out_ready = 1'b1;
        #1;
        checks++;
        if (req_ready !== 4'b0010) begin errors++; $display("FAIL mid_grant: got %0h expected 2", req_ready); end
        @(negedge clk);
        req_valid = '0;
        @(negedge clk);
        #1;
        checks++;
        if (busy !== 1'b1) begin errors++; $display("FAIL mid_busy: got %0b expected 1", busy); end
        nreset = 1'b0;
        #1;
        checks++;
        if (busy !== 1'b0 || out_valid !== 1'b0 || out_parity !== 1'b0 || out_id !== 2'd0 || req_ready !== 4'h0) begin
            errors++;
            $display("FAIL mid_reset: got busy=%0b valid=%0b par=%0b id=%0d ready=%0h expected all 0",
                     busy, out_valid, out_parity, out_id, req_ready);
        end
        @(negedge clk);
        nreset = 1'b1;
        for (int i = 0; i < 6; i++) begin
            #1;
            if (out_valid) seen = 1'b1;
            @(negedge clk);
        end
        checks++;
        if (seen) begin errors++; $display("FAIL mid_discard: got out_valid=1 expected 0"); end
        req_valid = 4'hF;
        #1;
        checks++;
        if (req_ready !== 4'b0001) begin errors++; $display("FAIL mid_regrant: got %0h expected 1", req_ready); end
        wait_result(1'b1, lat);
        checks++;
        if (lat != 4 || out_id !== 2'd0) begin
            errors++; $display("FAIL mid_result: got lat=%0d id=%0d expected 4 0", lat, out_id);
        end
        @(negedge clk);
    endtask

    task automatic w1_run(input logic [3:0] vld, input logic [3:0] dat,
                          input logic exp_par, input logic [1:0] exp_id);
        int lat = 0;
        @(negedge clk);
        w1_req_data = dat;
        w1_req_valid = vld;
        w1_out_ready = 1'b1;
        #1;
        checks++;
        if (w1_req_ready !== vld) begin errors++; $display("FAIL w1_grant: got %0h expected %0h", w1_req_ready, vld); end
        do begin
            @(negedge clk);
            w1_req_valid = '0;
            lat++;
            #1;
        end while (!w1_out_valid && lat < 8);
        checks++;
        if (lat != 2) begin errors++; $display("FAIL w1_latency: got %0d expected 2", lat); end
        checks++;
        if (w1_out_parity !== exp_par || w1_out_id !== exp_id) begin
            errors++; $display("FAIL w1_result: got par=%0b id=%0d expected %0b %0d", w1_out_parity, w1_out_id, exp_par, exp_id);
        end
        @(negedge clk);
        #1;
        checks++;
        if (w1_out_valid !== 1'b0) begin errors++; $display("FAIL w1_release: got %0b expected 0", w1_out_valid); end
    endtask

    task automatic test_width1();
        w1_run(4'b0001, 4'b0001, 1'b1 ^ ODD, 2'd0);
        w1_run(4'b0010, 4'b0000, ODD, 2'd1);
    endtask

    initial begin
        nreset = 1'b1;
        req_valid = '0;
        req_data = '0;
        out_ready = 1'b0;
        w1_req_valid = '0;
        w1_req_data = '0;
        w1_out_ready = 1'b1;
        #1;
        test_reset();
        test_single();
        test_round_robin();
        test_hold();
        test_reset_mid_run();
        test_width1();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/la_parity_seq.md
LA_PARITY_SEQ -- requirements
Module: la_parity_seq

Interface
REQ-001 SHALL have parameter PROP, default "DEFAULT": implementation property hint, no functional effect.
REQ-002 SHALL have parameter N, default 4: number of requesters, legal range 2..16.
REQ-003 SHALL have parameter WIDTH, default 8: request data width, legal range 1 or more.
REQ-004 SHALL have clk  input  1  single clock; all state rising-edge triggered.
REQ-005 SHALL have nreset  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have req_valid  input  N  per-requester request valid.
REQ-007 SHALL have req_ready  output  N  per-requester accept, one-hot or zero.
REQ-008 SHALL have req_data  input  N*WIDTH  requester i occupies bits [i*WIDTH +: WIDTH].
REQ-009 SHALL have out_valid  input/out_ready  output/input  1  result handshake (out_valid output, out_ready input).
REQ-010 SHALL have out_parity  output  1  computed parity of the accepted word.
REQ-011 SHALL have out_id  output  max(1,clog2(N))  index of the requester that owns the result.
REQ-012 SHALL have busy  output  1  high whenever state is not IDLE.

Function
REQ-013 SHALL share one 4-input XOR reduction slice among all requesters, sequenced by a 3-state FSM: IDLE, RUN, DONE.
REQ-014 SHALL, in IDLE with any req_valid high, grant exactly one requester by round-robin and assert its req_ready for that cycle only.
REQ-015 SHALL implement round-robin as: the first requester with req_valid high, searching upward from (last_grant+1) mod N.
REQ-016 SHALL, on the grant cycle, capture req_data of the granted requester and its index, then transition to RUN.
REQ-017 SHALL, in RUN, each cycle XOR the accumulator with the next 3 data bits, LSB first, zero-padding past WIDTH.
REQ-018 SHALL remain in RUN for exactly K = ceil(WIDTH/3) cycles, counted by a down-counter, then transition to DONE.
REQ-019 SHALL, in DONE, hold out_valid high with out_parity and out_id stable until out_ready is high, then return to IDLE.
REQ-020 SHALL give a latency of K+1 cycles from the grant edge to out_valid; no new grant while RUN or DONE.
REQ-021 SHALL keep req_ready low for all requesters outside IDLE; requesters hold req_valid and req_data until accepted.
REQ-022 SHALL ignore req_valid deasserted before grant; no request state is stored per requester.
REQ-023 SHALL, with out_ready held high, keep out_valid for exactly one cycle; the next grant is possible on the following cycle.
REQ-024 SHALL handle WIDTH=1 as K=1 and all-zero data as parity equal to the accumulator initial value.

Reset
REQ-025 SHALL, on nreset low and asynchronously, force state IDLE, req_ready 0, out_valid 0, out_parity 0, out_id 0, busy 0, and counter 0.
REQ-026 SHALL reset last_grant to N-1 so that requester 0 has first priority after reset.
REQ-027 SHALL discard any in-flight word on reset mid-RUN or mid-DONE, with no result emitted.

Configuration
REQ-028 SHALL, with macro LA_PARITY_SEQ_ODD_EN defined, initialise the accumulator to 1 at grant, giving odd parity.
REQ-029 SHALL, without LA_PARITY_SEQ_ODD_EN, initialise the accumulator to 0 at grant, giving even parity (XOR of bits).

Structure
REQ-030 SHALL place the FSM state encodings (IDLE=2'd0, RUN=2'd1, DONE=2'd2) and the K/counter-width derivation function in shared package la_parity_pkg.
REQ-031 SHALL instantiate la_xor4 as the single datapath sub-module, with inputs accumulator, bit0, bit1 and bit2.

Verification
REQ-032 SHALL cover: N=4, WIDTH=8, req_valid=4'b0001, data 8'hA5, out_ready=1 -> req_ready[0] one cycle, out_valid 4 cycles later, out_parity=0 (1 under ODD_EN), out_id=0.
REQ-033 SHALL cover: req_valid=4'b1111 held continuously with out_ready=1 -> grant order 0,1,2,3,0, each grant separated by 5 cycles.
REQ-034 SHALL cover: data 8'h07 from requester 2 with out_ready=0 for 3 cycles -> out_valid held for 4 cycles, out_parity=1, out_id=2 stable, busy high throughout.
REQ-035 SHALL cover: nreset pulsed low during RUN -> all outputs 0 immediately, no out_valid, next grant goes to requester 0.
REQ-036 SHALL cover: WIDTH=1, data 1'b1 -> RUN for 1 cycle, out_valid on the 2nd cycle after grant, out_parity=1.
